// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and constants for the mem_access load/store unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int ACK_TIMEOUT_DEFAULT = 16;

    // Width of a store-style funct3; load codes are folded onto these first.
    function automatic size_e f3_size(input logic [2:0] f3);
        case (f3)
            F3_B:    return SZ_B;
            F3_H:    return SZ_H;
            default: return SZ_W;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_if
//  Description : Word-aligned data-memory bus with req/ack handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );

endinterface
`default_nettype wire

// File: rtl/store_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : store_aligner
//  Description : Byte enables and lane-replicated store data for one access.
//  Revision    : 1.0 - initial release
// ============================================================================
module store_aligner
    import mem_pkg::*;
(
    input  wire  [2:0]  funct3_i,
    input  wire  [1:0]  off_i,
    input  wire  [31:0] wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (funct3_i)
            F3_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            F3_H: begin
                be_o    = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access
//  Description : RV32I MEM-stage load/store unit; one req/ack transaction per
//                access, right-aligned load data. Optional misalignment
//                trapping via MEM_ACCESS_MISALIGN_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  wire          clk,
    input  wire          rst,
    input  wire          valid_in,
    input  wire          is_load,
    input  wire          is_store,
    input  wire  [2:0]   funct3,
    input  wire  [31:0]  addr,
    input  wire  [31:0]  wdata,
    output logic         stall,
    output logic [31:0]  rdata_out,
    output logic         rdata_valid,
    output logic         misaligned,
    output logic         bus_err,
    mem_access_if.master dmem
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_BUSY = ST_BUSY;
    localparam logic [1:0] S_DONE = ST_DONE;

    localparam int             CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic [31:2]      addr_q, addr_d;
    logic [1:0]       off_q, off_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    size_e            size_q, size_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             mis_q, mis_d;
    logic             berr_q, berr_d;

    logic        w_req;
    logic        w_busy;
    logic [2:0]  w_f3;
    size_e       w_size;
    logic [31:0] w_addr;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load;

    assign w_req  = valid_in & (is_load | is_store);
    assign w_busy = (state_q == S_BUSY);

    // Loads are folded onto store width codes so one decoder serves both.
    always_comb begin
        w_f3 = funct3;
        if (!is_store) begin
            case (funct3)
                F3_B, F3_BU: w_f3 = F3_B;
                F3_H, F3_HU: w_f3 = F3_H;
                default:     w_f3 = F3_W;
            endcase
        end
    end

    assign w_size = f3_size(w_f3);

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    always_comb begin
        w_addr = addr;
        case (w_size)
            SZ_H:    w_misalign = addr[0];
            SZ_W:    w_misalign = |addr[1:0];
            default: w_misalign = 1'b0;
        endcase
    end
`else
    always_comb begin
        w_misalign = 1'b0;
        w_addr     = addr;
        case (w_size)
            SZ_H:    w_addr[0]   = 1'b0;
            SZ_W:    w_addr[1:0] = 2'b00;
            default: w_addr      = addr;
        endcase
    end
`endif

    store_aligner u_store_aligner (
        .funct3_i (w_f3),
        .off_i    (w_addr[1:0]),
        .wdata_i  (wdata),
        .be_o     (w_be),
        .wdata_o  (w_wdata)
    );

    assign w_shift = dmem.dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            SZ_B:    w_load = {24'h0, w_shift[7:0]};
            SZ_H:    w_load = {16'h0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        off_d    = off_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        size_d   = size_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        mis_d    = 1'b0;
        berr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_req) begin
                    we_d    = is_store;
                    addr_d  = w_addr[31:2];
                    off_d   = w_addr[1:0];
                    be_d    = w_be;
                    wdata_d = w_wdata;
                    size_d  = w_size;
                    cnt_d   = '0;
                    if (w_misalign) begin
                        mis_d   = 1'b1;
                        rdata_d = 32'h0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (dmem.dmem_ack) begin
                    rdata_d  = w_load;
                    rvalid_d = ~we_q;
                    state_d  = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0;
                    berr_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            off_q    <= 2'b00;
            be_q     <= 4'h0;
            wdata_q  <= 32'h0;
            size_q   <= SZ_B;
            rdata_q  <= 32'h0;
            rvalid_q <= 1'b0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            off_q    <= off_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            size_q   <= size_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    // Bus outputs are gated by BUSY so an async reset drops them at once.
    assign stall       = w_req & (state_q != S_DONE);
    assign rdata_out   = rdata_q;
    assign rdata_valid = rvalid_q;
    assign misaligned  = mis_q;
    assign bus_err     = berr_q;

    assign dmem.dmem_req   = w_busy;
    assign dmem.dmem_we    = w_busy & we_q;
    assign dmem.dmem_addr  = w_busy ? {addr_q, 2'b00} : 32'h0;
    assign dmem.dmem_be    = w_busy ? be_q : 4'h0;
    assign dmem.dmem_wdata = w_busy ? wdata_q : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_access
//  Description : Self-checking bench for mem_access: vector table, random
//                transactions against a reference model, reset corner case.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access;

    localparam int T = 16;

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_k;
        int          exp_done;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_berr;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        is_load;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata_out;
    logic        rdata_valid;
    logic        misaligned;
    logic        bus_err;

    int          checks;
    int          errors;
    logic [31:0] last_exp;
    logic [31:0] last_mask;

    vec_t tbl [13];

    mem_access_if dif ();

    mem_access #(.ACK_TIMEOUT(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .is_load     (is_load),
        .is_store    (is_store),
        .funct3      (funct3),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata_out   (rdata_out),
        .rdata_valid (rdata_valid),
        .misaligned  (misaligned),
        .bus_err     (bus_err),
        .dmem        (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Access size in bytes, straight from the RV32I width codes.
    function automatic int sz_of(input logic st, input logic [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input int sz);
        return (sz == 1) ? 32'h0000_00FF : (sz == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    endfunction

    function automatic vec_t build(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [31:0] a, input logic [31:0] wd,
                                   input logic [31:0] rd, input int k);
        vec_t        v;
        int          sz;
        int          off;
        logic [31:0] al;
        logic        acked;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rd; v.ack_k = k;
        sz = sz_of(st, f3);
        v.exp_mis = 1'b0;
        al = a;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        v.exp_mis = (a % sz) != 0;
`else
        al = a - (a % sz);
`endif
        off         = int'(al % 4);
        v.exp_addr  = al - off;
        v.exp_be    = (sz == 1) ? 4'(1 << off) : (sz == 2) ? 4'(3 << off) : 4'hF;
        v.exp_wdata = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                      (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
        acked       = (k >= 1) && (k <= T);
        v.exp_berr  = !v.exp_mis && !acked;
        v.exp_done  = v.exp_mis ? 1 : (acked ? k + 1 : T + 1);
        v.exp_rdata = (v.exp_mis || !acked) ? 32'h0 : (rd >> (8 * off)) & mask_of(sz);
        return v;
    endfunction

    task automatic run_txn(input vec_t v);
        int          done_c;
        int          req_n;
        int          exp_req;
        logic        bad;
        logic        seen;
        logic [31:0] a1, wd1;
        logic [3:0]  be1;
        logic        we1;
        logic [31:0] m;
        done_c = -1; req_n = 0; bad = 1'b0; seen = 1'b0;
        a1 = 32'h0; wd1 = 32'h0; be1 = 4'h0; we1 = 1'b0;
        exp_req = v.exp_mis ? 0 : v.exp_done - 1;
        m = (v.exp_mis || v.exp_berr) ? 32'hFFFF_FFFF : mask_of(sz_of(v.st, v.f3));
        @(posedge clk); #1;
        valid_in = 1'b1; is_load = v.ld; is_store = v.st; funct3 = v.f3;
        addr = v.addr; wdata = v.wdata; dif.dmem_rdata = v.rdata; dif.dmem_ack = 1'b0;
        @(negedge clk);
        check("c0_stall", 32'(stall), 32'd1);
        check("c0_req", 32'(dif.dmem_req), 32'd0);
        check("c0_pulses", 32'({rdata_valid, bus_err, misaligned}), 32'd0);
        check("rdata_hold", rdata_out & last_mask, last_exp);
        for (int c = 1; c <= 40 && done_c < 0; c++) begin
            @(posedge clk); #1;
            dif.dmem_ack = (c == v.ack_k);
            @(negedge clk);
            if (dif.dmem_req) begin
                req_n++;
                if (!seen) begin
                    seen = 1'b1;
                    a1 = dif.dmem_addr; we1 = dif.dmem_we; be1 = dif.dmem_be; wd1 = dif.dmem_wdata;
                end
                if (dif.dmem_addr !== v.exp_addr || dif.dmem_we !== v.st ||
                    (v.st && (dif.dmem_be !== v.exp_be || dif.dmem_wdata !== v.exp_wdata)))
                    bad = 1'b1;
            end
            if (!stall) done_c = c;
        end
        dif.dmem_ack = 1'b0;
        check("done_cycle", 32'(done_c), 32'(v.exp_done));
        check("req_cycles", 32'(req_n), 32'(exp_req));
        if (exp_req > 0) begin
            check("dmem_addr", a1, v.exp_addr);
            check("dmem_we", 32'(we1), 32'(v.st));
            if (v.st) begin
                check("dmem_be", 32'(be1), 32'(v.exp_be));
                check("dmem_wdata", wd1, v.exp_wdata);
            end
            check("bus_stable", 32'(bad), 32'd0);
        end
        check("rdata_valid", 32'(rdata_valid), 32'(v.ld & ~v.st & ~v.exp_mis & ~v.exp_berr));
        check("bus_err", 32'(bus_err), 32'(v.exp_berr));
        check("misaligned", 32'(misaligned), 32'(v.exp_mis));
        if (!v.st || v.exp_mis || v.exp_berr)
            check("rdata_out", rdata_out & m, v.exp_rdata);
        if (v.st && !v.exp_mis && !v.exp_berr) begin
            last_mask = 32'h0;
            last_exp  = 32'h0;
        end else begin
            last_mask = m;
            last_exp  = v.exp_rdata;
        end
    endtask

    logic        r_ld, r_st;
    logic [2:0]  r_f3;
    logic [31:0] r_a, r_wd, r_rd;
    int          r_k;

    initial begin
        checks = 0; errors = 0;
        last_exp = 32'h0; last_mask = 32'hFFFF_FFFF;
        rst = 1'b1; valid_in = 1'b0; is_load = 1'b0; is_store = 1'b0;
        funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
        dif.dmem_ack = 1'b0; dif.dmem_rdata = 32'h0;

        // ld st f3 addr wdata rdata ack_k | done addr be wdata rdata mis berr
        tbl[0]  = '{0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1,  2,  32'h100, 4'hF, 32'hDEADBEEF, 32'h0,        0, 0};
        tbl[1]  = '{0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0,        2,  3,  32'h100, 4'h8, 32'hA5A5A5A5, 32'h0,        0, 0};
        tbl[2]  = '{1, 0, 3'b001, 32'h202, 32'h0,        32'h80011234, 4,  5,  32'h200, 4'hC, 32'h0,        32'h00008001, 0, 0};
        tbl[3]  = '{1, 0, 3'b010, 32'h400, 32'h0,        32'h12345678, 0,  17, 32'h400, 4'hF, 32'h0,        32'h0,        0, 1};
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
        tbl[4]  = '{1, 0, 3'b010, 32'h301, 32'h0,        32'h11223344, 1,  1,  32'h0,   4'h0, 32'h0,        32'h0,        1, 0};
        tbl[10] = '{0, 1, 3'b001, 32'h103, 32'h00005A5A, 32'h0,        1,  1,  32'h0,   4'h0, 32'h0,        32'h0,        1, 0};
`else
        tbl[4]  = '{1, 0, 3'b010, 32'h301, 32'h0,        32'h11223344, 1,  2,  32'h300, 4'hF, 32'h0,        32'h11223344, 0, 0};
        tbl[10] = '{0, 1, 3'b001, 32'h103, 32'h00005A5A, 32'h0,        1,  2,  32'h100, 4'hC, 32'h5A5A5A5A, 32'h0,        0, 0};
`endif
        tbl[5]  = '{0, 1, 3'b001, 32'h106, 32'h1234BEEF, 32'h0,        1,  2,  32'h104, 4'hC, 32'hBEEFBEEF, 32'h0,        0, 0};
        tbl[6]  = '{1, 0, 3'b100, 32'h10B, 32'h0,        32'hAABBCCDD, 3,  4,  32'h108, 4'h8, 32'h0,        32'h000000AA, 0, 0};
        tbl[7]  = '{1, 0, 3'b000, 32'h00D, 32'h0,        32'h11223344, 2,  3,  32'h00C, 4'h2, 32'h0,        32'h00000033, 0, 0};
        tbl[8]  = '{1, 0, 3'b101, 32'h1FE, 32'h0,        32'hCAFE0000, 16, 17, 32'h1FC, 4'hC, 32'h0,        32'h0000CAFE, 0, 0};
        tbl[9]  = '{0, 1, 3'b111, 32'h020, 32'h01020304, 32'h0,        1,  2,  32'h020, 4'hF, 32'h01020304, 32'h0,        0, 0};
        tbl[11] = '{1, 0, 3'b110, 32'h500, 32'h0,        32'h87654321, 1,  2,  32'h500, 4'hF, 32'h0,        32'h87654321, 0, 0};
        tbl[12] = '{1, 1, 3'b000, 32'h041, 32'h000000C3, 32'h0,        1,  2,  32'h040, 4'h2, 32'hC3C3C3C3, 32'h0,        0, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_req", 32'(dif.dmem_req), 32'd0);
        check("reset_rdata", rdata_out, 32'h0);
        check("reset_pulses", 32'({rdata_valid, bus_err, misaligned}), 32'd0);
        check("reset_bus", 32'({dif.dmem_we, dif.dmem_be}) | dif.dmem_addr | dif.dmem_wdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_txn(tbl[i]);

        for (int i = 0; i < 40; i++) begin
            r_st = 1'($urandom_range(0, 1));
            r_ld = 1'($urandom_range(0, 1));
            if (!r_ld && !r_st) r_ld = 1'b1;
            r_f3 = 3'($urandom_range(0, 7));
            r_a  = $urandom;
            r_wd = $urandom;
            r_rd = $urandom;
            r_k  = $urandom_range(0, 5);
            run_txn(build(r_ld, r_st, r_f3, r_a, r_wd, r_rd, r_k));
        end

        // Reset in the second BUSY cycle of an LB, then a late ack.
        run_txn(tbl[11]);
        @(posedge clk); #1;
        valid_in = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0000_0041; dif.dmem_ack = 1'b0; dif.dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("rst_busy1_req", 32'(dif.dmem_req), 32'd1);
        @(posedge clk); #1;
        check("rst_busy2_req", 32'(dif.dmem_req), 32'd1);
        rst = 1'b1; valid_in = 1'b0; is_load = 1'b0;
        #1;
        check("rst_req_drop", 32'(dif.dmem_req), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_rdata", rdata_out, 32'h0);
        check("rst_addr", dif.dmem_addr, 32'h0);
        check("rst_pulses", 32'({rdata_valid, bus_err, misaligned}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        dif.dmem_ack = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("late_ack_valid", 32'(rdata_valid), 32'd0);
            check("late_ack_req", 32'(dif.dmem_req), 32'd0);
        end
        dif.dmem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_rdata", rdata_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
